// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle main controller for the MIPS datapath.
//
// A Moore state machine that sequences fetch, decode, execute, memory and
// write-back over several clocks. It shares one ALU and one unified memory
// port, and stalls on a level-based mem_req/mem_ready handshake. Every
// datapath mux select and write enable is a combinational decode of the
// registered state. The only exception is ir_write/pc_write in FETCH, which
// are also qualified by mem_ready.
//
// Optional feature macro: MC_CTRL_PERF_EN
//   When defined, two free-running performance counters are added:
//     cycle_cnt - clocks spent outside IDLE
//     instr_cnt - instructions retired (entries into FETCH, not from IDLE)
//   When undefined, neither the ports nor the counters exist.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   opcode[5:0]     IR[31:26], consulted in DECODE and MEMADR
//   zero            ALU zero flag (the PC enable gating uses it downstream)
//   mem_ready       memory completes the current access this cycle
//   mem_req         memory request, held until mem_ready
//   i_or_d          memory address select: 0 = PC, 1 = ALUOut
//   mem_read/write  access type, valid while mem_req = 1
//   ir_write        load IR
//   pc_write        unconditional PC load
//   pc_write_cond   PC load if zero = 1
//   pc_source[1:0]  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
//   alu_src_a       0 = PC, 1 = register A
//   alu_src_b[1:0]  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op[1:0]     00 add, 01 sub, 10 funct-decoded
//   reg_dst         0 = rt, 1 = rd
//   mem_to_reg      0 = ALUOut, 1 = MDR
//   reg_write       register-file write enable
//   exception       one-cycle pulse on an undefined opcode
//   state[3:0]      current state encoding (debug)
//   cycle_cnt[31:0], instr_cnt[31:0]   only with MC_CTRL_PERF_EN

module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       exception,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_EXCEPT = 4'd13
    } state_t;

    state_t cur_state;
    state_t next_state;

    // The zero flag gates pc_write_cond in the PC enable logic outside this
    // block. The Moore outputs never depend on it, so it is only tapped here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = cur_state;

    // The state register. Reset forces IDLE immediately, so an in-flight
    // memory request drops without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic and Moore output decode. Every output defaults to 0,
    // and each state raises only the signals it needs. Unused codes 14-15
    // fall into the default arm and recover to IDLE.
    always_comb begin
        next_state    = cur_state;
        mem_req       = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        exception     = 1'b0;

        case (cur_state)
            S_IDLE: begin
                next_state = S_FETCH;
            end

            // The PC+4 increment and the IR load commit only in the cycle
            // the instruction word arrives. This keeps a stalled fetch
            // idempotent.
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end

            // The branch target is computed speculatively here so BRANCH
            // can use ALUOut while the ALU does the compare.
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_EXCEPT;
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    next_state = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_EXCEPT;
                end
            end

            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end

            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_RWB;
            end

            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = S_FETCH;
            end

            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end

            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = S_FETCH;
            end

            S_EXCEPT: begin
                exception  = 1'b1;
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                next_state = S_FETCH;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    // Cycle counter: counts every clock outside IDLE and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
        end else if (cur_state != S_IDLE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Instruction counter: one count per entry into FETCH. A fetch stall is
    // not an entry. The reset-exit entry from IDLE is not a completed
    // instruction. An exception does count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 32'd0;
        end else if (next_state == S_FETCH && cur_state != S_FETCH
                     && cur_state != S_IDLE) begin
            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- directed self-checking bench for mc_ctrl.
//
// Each scenario task walks one instruction class through the controller.
// After every clock edge, it compares the debug state and the full output
// vector against hand-written per-state expectations. Outputs are packed
// in the order:
//   {mem_req, i_or_d, mem_read, mem_write,
//    ir_write, pc_write, pc_write_cond,
//    pc_source[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0],
//    reg_dst, mem_to_reg, reg_write, exception}

module tb_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        exception;
    logic [3:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    logic [17:0] outs;
    logic        pc_load;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] EXP_IDLE    = 18'b0000_000_00_0_00_00_0000;
    localparam logic [17:0] EXP_FETCH_R = 18'b1010_110_00_0_01_00_0000;
    localparam logic [17:0] EXP_FETCH_W = 18'b1010_000_00_0_01_00_0000;
    localparam logic [17:0] EXP_DECODE  = 18'b0000_000_00_0_11_00_0000;
    localparam logic [17:0] EXP_MEMADR  = 18'b0000_000_00_1_10_00_0000;
    localparam logic [17:0] EXP_MEMRD   = 18'b1110_000_00_0_00_00_0000;
    localparam logic [17:0] EXP_MEMWB   = 18'b0000_000_00_0_00_00_0110;
    localparam logic [17:0] EXP_MEMWR   = 18'b1101_000_00_0_00_00_0000;
    localparam logic [17:0] EXP_EXEC    = 18'b0000_000_00_1_00_10_0000;
    localparam logic [17:0] EXP_RWB     = 18'b0000_000_00_0_00_00_1010;
    localparam logic [17:0] EXP_BRANCH  = 18'b0000_001_01_1_00_01_0000;
    localparam logic [17:0] EXP_ADDIEX  = 18'b0000_000_00_1_10_00_0000;
    localparam logic [17:0] EXP_ADDIWB  = 18'b0000_000_00_0_00_00_0010;
    localparam logic [17:0] EXP_JUMP    = 18'b0000_010_10_0_00_00_0000;
    localparam logic [17:0] EXP_EXCEPT  = 18'b0000_010_11_0_00_00_0001;

    assign outs = {mem_req, i_or_d, mem_read, mem_write,
                   ir_write, pc_write, pc_write_cond,
                   pc_source, alu_src_a, alu_src_b, alu_op,
                   reg_dst, mem_to_reg, reg_write, exception};

    // The datapath's PC enable, as it would be built around the controller.
    assign pc_load = pc_write | (pc_write_cond & zero);

    mc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .exception     (exception),
        .state         (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle a little past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({state, outs} !== {4'd0, EXP_IDLE}) begin
            errors++;
            $display("[TB] FAIL reset_held: got state=%0d outs=%b, want state=0 outs=%b", state, outs, EXP_IDLE);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {4'd0, EXP_IDLE}) begin
            errors++;
            $display("[TB] FAIL reset_release: got state=%0d outs=%b, want state=0 outs=%b", state, outs, EXP_IDLE);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got cycle=%0d instr=%0d, want 0 0", cycle_cnt, instr_cnt);
        end
`endif
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
    endtask

    task automatic test_rtype();
        opcode    = 6'd0;
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({state, outs} !== {4'd2, EXP_DECODE}) begin
            errors++;
            $display("[TB] FAIL rtype_decode: got state=%0d outs=%b, want state=2 outs=%b", state, outs, EXP_DECODE);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd7, EXP_EXEC}) begin
            errors++;
            $display("[TB] FAIL rtype_exec: got state=%0d outs=%b, want state=7 outs=%b", state, outs, EXP_EXEC);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd8, EXP_RWB}) begin
            errors++;
            $display("[TB] FAIL rtype_rwb: got state=%0d outs=%b, want state=8 outs=%b", state, outs, EXP_RWB);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL rtype_refetch: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if (cycle_cnt !== 32'd4 || instr_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL rtype_counters: got cycle=%0d instr=%0d, want 4 1", cycle_cnt, instr_cnt);
        end
`endif
    endtask

    task automatic test_fetch_stall_addi();
        opcode    = 6'd8;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_W}) begin
            errors++;
            $display("[TB] FAIL stall_fetch_wait: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_W);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_W}) begin
            errors++;
            $display("[TB] FAIL stall_fetch_hold: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_W);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL stall_fetch_ready: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
        tick();
        tick();
        checks++;
        if ({state, outs} !== {4'd10, EXP_ADDIEX}) begin
            errors++;
            $display("[TB] FAIL addi_ex: got state=%0d outs=%b, want state=10 outs=%b", state, outs, EXP_ADDIEX);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd11, EXP_ADDIWB}) begin
            errors++;
            $display("[TB] FAIL addi_wb: got state=%0d outs=%b, want state=11 outs=%b", state, outs, EXP_ADDIWB);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL addi_refetch: got state=%0d, want state=1", state);
        end
    endtask

    task automatic test_lw_wait();
        opcode    = 6'd35;
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({state, outs} !== {4'd2, EXP_DECODE}) begin
            errors++;
            $display("[TB] FAIL lw_decode: got state=%0d outs=%b, want state=2 outs=%b", state, outs, EXP_DECODE);
        end
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({state, outs} !== {4'd3, EXP_MEMADR}) begin
            errors++;
            $display("[TB] FAIL lw_memadr: got state=%0d outs=%b, want state=3 outs=%b", state, outs, EXP_MEMADR);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd4, EXP_MEMRD}) begin
            errors++;
            $display("[TB] FAIL lw_memrd_1: got state=%0d outs=%b, want state=4 outs=%b", state, outs, EXP_MEMRD);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd4, EXP_MEMRD}) begin
            errors++;
            $display("[TB] FAIL lw_memrd_2: got state=%0d outs=%b, want state=4 outs=%b", state, outs, EXP_MEMRD);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {4'd4, EXP_MEMRD}) begin
            errors++;
            $display("[TB] FAIL lw_memrd_3: got state=%0d outs=%b, want state=4 outs=%b", state, outs, EXP_MEMRD);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd5, EXP_MEMWB}) begin
            errors++;
            $display("[TB] FAIL lw_memwb: got state=%0d outs=%b, want state=5 outs=%b", state, outs, EXP_MEMWB);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL lw_refetch: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
    endtask

    task automatic test_sw();
        opcode    = 6'd43;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({state, outs} !== {4'd6, EXP_MEMWR}) begin
            errors++;
            $display("[TB] FAIL sw_memwr: got state=%0d outs=%b, want state=6 outs=%b", state, outs, EXP_MEMWR);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL sw_refetch: got state=%0d, want state=1", state);
        end
    endtask

    task automatic test_beq();
        opcode    = 6'd4;
        mem_ready = 1'b1;
        zero      = 1'b1;
        tick();
        tick();
        checks++;
        if ({state, outs} !== {4'd9, EXP_BRANCH}) begin
            errors++;
            $display("[TB] FAIL beq_taken_state: got state=%0d outs=%b, want state=9 outs=%b", state, outs, EXP_BRANCH);
        end
        checks++;
        if (pc_load !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beq_taken_pcload: got %b, want 1", pc_load);
        end
        tick();
        zero = 1'b0;
        tick();
        tick();
        checks++;
        if ({state, outs} !== {4'd9, EXP_BRANCH}) begin
            errors++;
            $display("[TB] FAIL beq_nottaken_state: got state=%0d outs=%b, want state=9 outs=%b", state, outs, EXP_BRANCH);
        end
        checks++;
        if (pc_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_nottaken_pcload: got %b, want 0", pc_load);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL beq_refetch: got state=%0d, want state=1", state);
        end
    endtask

    task automatic test_jump();
        opcode = 6'd2;
        tick();
        tick();
        checks++;
        if ({state, outs} !== {4'd12, EXP_JUMP}) begin
            errors++;
            $display("[TB] FAIL jump_state: got state=%0d outs=%b, want state=12 outs=%b", state, outs, EXP_JUMP);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("[TB] FAIL jump_refetch: got state=%0d, want state=1", state);
        end
    endtask

    task automatic test_undefined();
        opcode = 6'd63;
        tick();
        checks++;
        if ({state, outs} !== {4'd2, EXP_DECODE}) begin
            errors++;
            $display("[TB] FAIL undef_decode: got state=%0d outs=%b, want state=2 outs=%b", state, outs, EXP_DECODE);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd13, EXP_EXCEPT}) begin
            errors++;
            $display("[TB] FAIL undef_except: got state=%0d outs=%b, want state=13 outs=%b", state, outs, EXP_EXCEPT);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL undef_refetch: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
    endtask

    task automatic test_reset_mid_sw();
        opcode    = 6'd43;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({state, outs} !== {4'd6, EXP_MEMWR}) begin
            errors++;
            $display("[TB] FAIL midsw_memwr: got state=%0d outs=%b, want state=6 outs=%b", state, outs, EXP_MEMWR);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, outs} !== {4'd0, EXP_IDLE}) begin
            errors++;
            $display("[TB] FAIL midsw_async_drop: got state=%0d outs=%b, want state=0 outs=%b", state, outs, EXP_IDLE);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midsw_counters: got cycle=%0d instr=%0d, want 0 0", cycle_cnt, instr_cnt);
        end
`endif
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midsw_idle: got state=%0d, want state=0", state);
        end
        tick();
        checks++;
        if ({state, outs} !== {4'd1, EXP_FETCH_R}) begin
            errors++;
            $display("[TB] FAIL midsw_restart: got state=%0d outs=%b, want state=1 outs=%b", state, outs, EXP_FETCH_R);
        end
    endtask

    initial begin
        $display("[TB] mc_ctrl directed test start");
        test_reset();
        test_rtype();
        test_fetch_stall_addi();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jump();
        test_undefined();
        test_reset_mid_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
